// File: rtl/port_bus_arb_pkg.sv
// Shared definitions for the port bus arbiter: FSM states and port block address map.
package port_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_DIR3  = 4'h3;
  localparam logic [3:0] ADDR_DIR4  = 4'h4;
  localparam logic [3:0] ADDR_DIR5  = 4'h5;
  localparam logic [3:0] ADDR_DIR6  = 4'h6;
  localparam logic [3:0] ADDR_PORT7 = 4'h7;
  localparam logic [3:0] ADDR_PORT8 = 4'h8;
  localparam logic [3:0] ADDR_PORT9 = 4'h9;
  localparam logic [3:0] ADDR_PORTA = 4'ha;

  localparam logic [3:0] WR_LO_DEF = ADDR_DIR3;
  localparam logic [3:0] WR_HI_DEF = ADDR_PORTA;
  localparam logic [3:0] RD_LO_DEF = ADDR_PORT7;

endpackage

// File: rtl/port_bus_arb_rr_arb2.sv
// Two-way round-robin picker; the pointer names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_reg;

  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt = ptr_reg ? 2'b10 : 2'b01;
    end
  end

  // After any grant the pointer moves to the requester that did not win.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr_reg <= ~gnt[1];
    end
  end

endmodule

// File: rtl/port_bus_arb.sv
// Two-requester arbiter/sequencer for the 4-bit port block (IDLE -> ISSUE -> ACK).
// Optional macro PORT_BUS_ARB_ADDR_CHECK_EN suppresses illegal-address accesses and flags err.
module port_bus_arb
  import port_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter logic [ADDR_W-1:0] WR_LO = ADDR_W'(WR_LO_DEF),
  parameter logic [ADDR_W-1:0] WR_HI = ADDR_W'(WR_HI_DEF),
  parameter logic [ADDR_W-1:0] RD_LO = ADDR_W'(RD_LO_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              sync,
  output logic [ADDR_W-1:0] datai,
  output logic [DATA_W-1:0] acci,
  input  logic [DATA_W-1:0] porti_mux
);

`ifdef PORT_BUS_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  state_t state_reg, state_next;

  logic [1:0]        arb_gnt;
  logic              arb_adv;
  logic              sel_id, sel_we, sel_bad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              id_reg, id_next;
  logic              we_reg, we_next;
  logic              bad_reg, bad_next;
  logic              sync_reg, sync_next;
  logic [ADDR_W-1:0] datai_reg, datai_next;
  logic [DATA_W-1:0] acci_reg, acci_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [1:0]        ack_reg, ack_next;
  logic [1:0]        err_reg, err_next;
  logic [DATA_W-1:0] rdata_reg [2];
  logic [DATA_W-1:0] rdata_next [2];

  assign arb_adv = (state_reg == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({r1_req, r0_req}),
    .advance (arb_adv),
    .gnt     (arb_gnt)
  );

  assign sel_id    = arb_gnt[1];
  assign sel_we    = sel_id ? r1_we    : r0_we;
  assign sel_addr  = sel_id ? r1_addr  : r0_addr;
  assign sel_wdata = sel_id ? r1_wdata : r0_wdata;
  // Reads share the upper bound with writes; only the lower bound differs.
  assign sel_bad   = ADDR_CHECK &&
                     (sel_we ? ((sel_addr < WR_LO) || (sel_addr > WR_HI))
                             : ((sel_addr < RD_LO) || (sel_addr > WR_HI)));

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    we_next    = we_reg;
    bad_next   = bad_reg;
    sync_next  = 1'b0;
    datai_next = datai_reg;
    acci_next  = acci_reg;
    gnt_next   = 2'b00;
    ack_next   = 2'b00;
    err_next   = 2'b00;
    rdata_next = rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          state_next = ST_ISSUE;
          id_next    = sel_id;
          we_next    = sel_we;
          bad_next   = sel_bad;
          datai_next = sel_addr;
          acci_next  = sel_wdata;
          sync_next  = sel_we && !sel_bad;
          gnt_next   = arb_gnt;
        end
      end
      ST_ISSUE: begin
        state_next       = ST_ACK;
        ack_next[id_reg] = 1'b1;
        err_next[id_reg] = bad_reg;
        if (bad_reg) begin
          rdata_next[id_reg] = '0;
        end else if (!we_reg) begin
          rdata_next[id_reg] = porti_mux;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      id_reg       <= 1'b0;
      we_reg       <= 1'b0;
      bad_reg      <= 1'b0;
      sync_reg     <= 1'b0;
      datai_reg    <= '0;
      acci_reg     <= '0;
      gnt_reg      <= 2'b00;
      ack_reg      <= 2'b00;
      err_reg      <= 2'b00;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
    end else begin
      state_reg    <= state_next;
      id_reg       <= id_next;
      we_reg       <= we_next;
      bad_reg      <= bad_next;
      sync_reg     <= sync_next;
      datai_reg    <= datai_next;
      acci_reg     <= acci_next;
      gnt_reg      <= gnt_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      rdata_reg[0] <= rdata_next[0];
      rdata_reg[1] <= rdata_next[1];
    end
  end

  assign sync     = sync_reg;
  assign datai    = datai_reg;
  assign acci     = acci_reg;
  assign r0_gnt   = gnt_reg[0];
  assign r1_gnt   = gnt_reg[1];
  assign r0_ack   = ack_reg[0];
  assign r1_ack   = ack_reg[1];
  assign r0_err   = err_reg[0];
  assign r1_err   = err_reg[1];
  assign r0_rdata = rdata_reg[0];
  assign r1_rdata = rdata_reg[1];

endmodule

// File: tb/tb_port_bus_arb.sv
// Self-checking bench for port_bus_arb: transaction-timed reference model plus directed scenarios.
module tb_port_bus_arb;

`ifdef PORT_BUS_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [3:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_gnt, r0_ack, r0_err, r1_gnt, r1_ack, r1_err;
  logic [3:0] r0_rdata, r1_rdata;
  logic       sync;
  logic [3:0] datai, acci, porti_mux;
  logic [3:0] pins [16];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  port_bus_arb dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .sync(sync), .datai(datai), .acci(acci), .porti_mux(porti_mux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port block read side: pins of port7..porta, zero for everything else.
  always_comb begin
    porti_mux = 4'h0;
    if (datai >= 4'h7 && datai <= 4'ha) porti_mux = pins[datai];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a transaction taken at edge t shows ISSUE values after t and ack after t+1;
  // the next request can be taken at edge t+3.
  bit         m_valid = 1'b0;
  bit         m_ptr, m_id, m_we, m_bad;
  int         t_start;
  logic [3:0] m_addr, m_wdata;
  logic       e_sync;
  logic [3:0] e_datai, e_acci;
  logic [1:0] e_gnt, e_ack, e_err;
  logic [3:0] e_rdata [2];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_valid = 1'b1;
      t_start = -10;
      m_ptr = 1'b0;
      e_sync = 1'b0; e_datai = 4'h0; e_acci = 4'h0;
      e_gnt = 2'b00; e_ack = 2'b00; e_err = 2'b00;
      e_rdata[0] = 4'h0; e_rdata[1] = 4'h0;
    end else if (m_valid) begin
      e_sync = 1'b0; e_gnt = 2'b00; e_ack = 2'b00; e_err = 2'b00;
      if (cyc - t_start == 1) begin
        e_ack[m_id] = 1'b1;
        e_err[m_id] = m_bad;
        if (m_bad) e_rdata[m_id] = 4'h0;
        else if (!m_we) e_rdata[m_id] = (m_addr >= 4'h7 && m_addr <= 4'ha) ? pins[m_addr] : 4'h0;
      end else if (cyc - t_start >= 3 && (r0_req || r1_req)) begin
        m_id    = (r0_req && r1_req) ? m_ptr : r1_req;
        m_ptr   = !m_id;
        m_we    = m_id ? r1_we : r0_we;
        m_addr  = m_id ? r1_addr : r0_addr;
        m_wdata = m_id ? r1_wdata : r0_wdata;
        m_bad   = CHK && (m_we ? (m_addr < 4'h3 || m_addr > 4'ha)
                               : (m_addr < 4'h7 || m_addr > 4'ha));
        e_datai = m_addr;
        e_acci  = m_wdata;
        e_sync  = m_we && !m_bad;
        e_gnt[m_id] = 1'b1;
        t_start = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_sync",   sync,     e_sync);
      check("m_datai",  datai,    e_datai);
      check("m_acci",   acci,     e_acci);
      check("m_r0_gnt", r0_gnt,   e_gnt[0]);
      check("m_r1_gnt", r1_gnt,   e_gnt[1]);
      check("m_r0_ack", r0_ack,   e_ack[0]);
      check("m_r1_ack", r1_ack,   e_ack[1]);
      check("m_r0_err", r0_err,   e_err[0]);
      check("m_r1_err", r1_err,   e_err[1]);
      check("m_r0_rd",  r0_rdata, e_rdata[0]);
      check("m_r1_rd",  r1_rdata, e_rdata[1]);
    end
  end

  int win [6];
  int nwin;

  initial begin
    rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    for (int i = 0; i < 16; i++) pins[i] = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write dir3
    r0_req = 1; r0_we = 1; r0_addr = 4'h3; r0_wdata = 4'h0;
    @(negedge clk); r0_req = 0;
    check("wr_gnt", r0_gnt, 1); check("wr_sync", sync, 1);
    check("wr_datai", datai, 4'h3); check("wr_acci", acci, 4'h0);
    @(negedge clk);
    check("wr_ack", r0_ack, 1);
    @(negedge clk);
    check("wr_ack_end", r0_ack, 0);
    @(negedge clk);

    // Read port7 by requester 1
    pins[7] = 4'h5; pins[3] = 4'hf;
    r1_req = 1; r1_we = 0; r1_addr = 4'h7; r1_wdata = 4'h2;
    @(negedge clk); r1_req = 0; r1_addr = 4'h9;
    check("rd_sync", sync, 0); check("rd_datai", datai, 4'h7);
    @(negedge clk);
    check("rd_ack", r1_ack, 1); check("rd_data", r1_rdata, 4'h5); check("rd_err", r1_err, 0);
    @(negedge clk);

    // Reset mid-traffic, then contention
    r1_req = 1; r1_we = 1; r1_addr = 4'h8; r1_wdata = 4'hb;
    @(negedge clk); rst = 1;
    @(negedge clk);
    check("rst_sync", sync, 0); check("rst_datai", datai, 0); check("rst_acci", acci, 0);
    check("rst_gnt", {r1_gnt, r0_gnt}, 0); check("rst_ack", {r1_ack, r0_ack}, 0);
    check("rst_err", {r1_err, r0_err}, 0); check("rst_rdata", {r1_rdata, r0_rdata}, 0);
    @(negedge clk);
    rst = 0;
    r0_req = 1; r0_we = 1; r0_addr = 4'h4; r0_wdata = 4'h1;
    r1_req = 1; r1_we = 0; r1_addr = 4'ha;
    pins[10] = 4'hc;
    @(negedge clk); r0_req = 0;
    check("ct_r0_gnt", r0_gnt, 1); check("ct_r1_gnt", r1_gnt, 0);
    @(negedge clk); check("ct_r0_ack", r0_ack, 1);
    @(negedge clk);
    @(negedge clk); r1_req = 0; check("ct_r1_gnt4", r1_gnt, 1);
    @(negedge clk); check("ct_r1_ack", r1_ack, 1); check("ct_r1_rd", r1_rdata, 4'hc);
    @(negedge clk);

    // Continuous contention alternates grants starting with requester 0
    for (int i = 0; i < 6; i++) win[i] = 2;
    nwin = 0;
    r0_req = 1; r1_req = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if ((r0_gnt || r1_gnt) && nwin < 6) begin
        win[nwin] = r1_gnt ? 1 : 0;
        nwin++;
      end
    end
    r0_req = 0; r1_req = 0;
    check("alt0", win[0], 0); check("alt1", win[1], 1);
    check("alt2", win[2], 0); check("alt3", win[3], 1);
    repeat (3) @(negedge clk);

    // Abort during ISSUE
    r0_req = 1; r0_we = 1; r0_addr = 4'h4; r0_wdata = 4'h6;
    @(negedge clk); check("ab_gnt", r0_gnt, 1); rst = 1; r0_req = 0;
    @(negedge clk); check("ab_noack", r0_ack, 0); check("ab_sync", sync, 0);
    rst = 0; pins[8] = 4'ha;
    r1_req = 1; r1_we = 0; r1_addr = 4'h8;
    @(negedge clk); check("ab_r1_gnt", r1_gnt, 1); r1_req = 0;
    @(negedge clk); check("ab_r1_ack", r1_ack, 1); check("ab_r1_rd", r1_rdata, 4'ha);
    @(negedge clk);

    // Out-of-range write
    r0_req = 1; r0_we = 1; r0_addr = 4'hc; r0_wdata = 4'h9;
    @(negedge clk); r0_req = 0;
    check("ft_datai", datai, 4'hc);
    if (CHK) check("ft_sync_off", sync, 0);
    else     check("ft_sync_on",  sync, 1);
    @(negedge clk);
    check("ft_ack", r0_ack, 1);
    check("ft_err", r0_err, CHK ? 1 : 0);
    if (CHK) check("ft_rdata", r0_rdata, 0);
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 63) == 0);
      r0_req   = $urandom_range(0, 1) == 1;
      r0_we    = $urandom_range(0, 1) == 1;
      r0_addr  = 4'($urandom_range(0, 15));
      r0_wdata = 4'($urandom_range(0, 15));
      r1_req   = $urandom_range(0, 1) == 1;
      r1_we    = $urandom_range(0, 1) == 1;
      r1_addr  = 4'($urandom_range(0, 15));
      r1_wdata = 4'($urandom_range(0, 15));
      for (int p = 7; p <= 10; p++) pins[p] = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    rst = 0; r0_req = 0; r1_req = 0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
